gpio_in_debounce: RTL and testbench
===================================

Name: gpio_in_debounce

Overview:
Input conditioner for external GPIO pins, sitting directly upstream of the memory-mapped GPIO read peripheral. It drives that peripheral's `in` bus.
- Synchronises each asynchronous pin into the `clk` domain.
- Debounces each bit independently with a per-bit stable-count filter.
- Emits one-cycle rise/fall strobes when a filtered bit changes.
- Firmware reads a clean, glitch-free level; edge strobes are available to other logic.

Parameters:
- BIT, 1, number of pins (≥1).
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles a new level must hold before acceptance (≥1; 0 is an elaboration error).
- RESET_VAL, 0, BIT-wide reset level for the sync flops and `out`.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is not synchronised inside the block.
- pin  in  BIT  raw external pins, asynchronous to clk.
- out  out  BIT  debounced level; feeds the GPIO read peripheral `in`.
- rise  out  BIT  one-cycle pulse per bit on an accepted 0→1 change.
- fall  out  BIT  one-cycle pulse per bit on an accepted 1→0 change.
- edge_clr  in  BIT  clear sticky edge flags. Present only with the optional feature.
- irq  out  1  OR of sticky edge flags. Present only with the optional feature.

Behaviour:
Interface
- One clock, `clk`.
- Reset `resetn` is asynchronous and active-low; polarity and synchronicity are fixed.

Reset (`resetn`=0)
- s1, s2, out = RESET_VAL.
- All counters = 0.
- rise, fall = 0.
- Sticky flags = 0 and irq = 0 (optional feature).
- Sync flops reset to RESET_VAL so that no spurious edge fires after reset when pins already sit at RESET_VAL.

Synchroniser
- Per bit, two flops: s1 <= pin, then s2 <= s1.
- s2 is the only value the filter uses.

Filter (per bit i)
- Counter cnt_i, width $clog2(DEBOUNCE_CYCLES+1). Each clock:
  - If s2[i] == out[i]: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: out[i] <= s2[i], cnt_i <= 0, and rise[i] <= s2[i] while fall[i] <= ~s2[i].
  - Else: cnt_i <= cnt_i + 1.
- rise and fall default to 0 every cycle, so each is a one-cycle pulse.
- The pulse is registered and is high during the same cycle in which `out` first shows the new value.

Latency
- A level first sampled into s1 at edge 0 and held steady updates `out` at edge DEBOUNCE_CYCLES+1.
- With DEBOUNCE_CYCLES=1, `out` updates at edge 2.

Boundary conditions
- If the level reverts before acceptance, the counter clears and there is no output change or pulse. Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- The counter never wraps: it saturates by construction at DEBOUNCE_CYCLES-1 before acceptance.
- rise[i] and fall[i] are never both high.
- Bits are fully independent; simultaneous changes on several bits produce simultaneous pulses.
- Reset asserted mid-count discards the count immediately, with no pulse. Filtering restarts from RESET_VAL after release.

Optional Feature:
Macro: GPIO_DEBOUNCE_IRQ_EN

With the macro defined:
- Add a per-bit sticky register flag[i].
- Each cycle, flag[i] <= (flag[i] & ~edge_clr[i]) | rise[i] | fall[i]. A new edge in the same cycle as a clear wins, so no edge is lost.
- irq = |flag, registered, so it asserts one cycle after the pulse.
- Ports `edge_clr` and `irq` exist only in this build.

Without the macro:
- The flag logic, `edge_clr` and `irq` are absent.
- Filter behaviour is identical in both builds.

Decomposition:
- Package gpio_pkg:
  - function/localparam for the counter width, $clog2(DEBOUNCE_CYCLES+1).
  - typedef for the per-bit filter state (counter and level).
  - constant GPIO_SYNC_STAGES = 2.
- Sub-module gpio_debounce_bit: one-bit synchroniser, filter and pulse generation.
- Top module gpio_in_debounce: instantiates BIT copies in a generate loop, plus the optional flag/irq logic.

Test Plan:
All scenarios use BIT=2, DEBOUNCE_CYCLES=4, RESET_VAL=0 unless stated.
1. Reset with pin=2'b00, release, hold pin → out=0, rise=fall=0 indefinitely.
2. pin[0] 0→1, first sampled at edge 0, held → out[0]=1 from edge 5; rise[0]=1 only in that cycle; fall=0.
3. pin[0] high for 3 cycles, then low → out[0] stays 0; no rise or fall pulse.
4. Both bits toggle 0→1 on the same edge, then back 1→0 after 10 cycles:
   - rise=2'b11 for one cycle.
   - Later fall=2'b11 for one cycle, 5 edges after the 1→0 sample.
5. pin[1] held high, resetn pulsed low at cnt=2 → out=0 immediately (asynchronous), no pulse; after release, out[1]=1 at edge 5 after pin is re-sampled.
6. With GPIO_DEBOUNCE_IRQ_EN:
   - rise[0] → irq=1 on the next cycle.
   - edge_clr=2'b01 → irq=0 on the next cycle.
   - edge_clr coincident with a new edge → flag stays 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input conditioner.
//   GPIO_SYNC_STAGES : depth of the per-pin synchroniser
//   GPIO_CNT_W_MAX   : widest stable-count counter the filter state can hold
//   gpio_cnt_width() : counter width needed to count to a given debounce length
//   gpio_filt_t      : per-bit filter state (stable counter + accepted level)
// -----------------------------------------------------------------------------
package gpio_pkg;

    localparam int GPIO_SYNC_STAGES = 32'sd2;
    localparam int GPIO_CNT_W_MAX   = 32'sd16;

    // Bits needed to hold values 0..cycles; a degenerate length still yields 1.
    function automatic int gpio_cnt_width(input int cycles);
        int w;
        if (cycles < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = $clog2(cycles + 32'sd1);
        end
        return w;
    endfunction

    // The counter field is sized for the largest supported debounce length;
    // each instance drives only its low bits and ties the rest to zero.
    typedef struct packed {
        logic [GPIO_CNT_W_MAX-1:0] cnt;
        logic                      level;
    } gpio_filt_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
// One pin: two-flop synchroniser, stable-count filter and edge pulse generator.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   pin    : raw asynchronous pin
//   out    : debounced level (registered)
//   rise   : one-cycle pulse on an accepted 0->1 change (registered)
//   fall   : one-cycle pulse on an accepted 1->0 change (registered)
// -----------------------------------------------------------------------------
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 32'sd16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = gpio_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);

    if ((DEBOUNCE_CYCLES < 32'sd1) || (CNT_W > GPIO_CNT_W_MAX)) begin : g_bad_param
        $error("gpio_debounce_bit: DEBOUNCE_CYCLES out of range");
    end

    logic [GPIO_SYNC_STAGES-1:0] r_sync;
    logic                        w_s2;
    gpio_filt_t                  r_filt;
    gpio_filt_t                  w_filt_next;
    logic                        r_rise;
    logic                        w_rise_next;
    logic                        r_fall;
    logic                        w_fall_next;

    assign w_s2 = r_sync[GPIO_SYNC_STAGES-1];

    // Synchroniser shift chain; resets to RESET_VAL so an idle pin at reset level causes no edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= {GPIO_SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[GPIO_SYNC_STAGES-2:0], pin};
        end
    end

    // Filter next state: a new level must be seen DEBOUNCE_CYCLES times in a row.
    always_comb begin
        w_filt_next = r_filt;
        w_rise_next = 1'b0;
        w_fall_next = 1'b0;
        if (w_s2 == r_filt.level) begin
            w_filt_next.cnt = '0;
        end else if (r_filt.cnt[CNT_W-1:0] == CNT_LAST) begin
            w_filt_next.level = w_s2;
            w_filt_next.cnt   = '0;
            w_rise_next       = w_s2;
            w_fall_next       = ~w_s2;
        end else begin
            w_filt_next.cnt            = '0;
            w_filt_next.cnt[CNT_W-1:0] = r_filt.cnt[CNT_W-1:0] + CNT_W'(32'd1);
        end
    end

    // Filter state and edge pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_filt.cnt   <= '0;
            r_filt.level <= RESET_VAL;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
        end else begin
            r_filt <= w_filt_next;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
        end
    end

    assign out  = r_filt.level;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/gpio_in_debounce.sv
// -----------------------------------------------------------------------------
// gpio_in_debounce
// Input conditioner for BIT external GPIO pins: synchronise, debounce each bit
// independently and emit one-cycle rise/fall strobes.
//   clk      : system clock
//   resetn   : asynchronous active-low reset (deassertion not synchronised here)
//   pin      : raw asynchronous pins
//   out      : debounced levels, feeding the GPIO read peripheral
//   rise     : per-bit one-cycle pulse on an accepted 0->1 change
//   fall     : per-bit one-cycle pulse on an accepted 1->0 change
//   edge_clr : clear sticky edge flags       (GPIO_DEBOUNCE_IRQ_EN builds only)
//   irq      : OR of sticky edge flags       (GPIO_DEBOUNCE_IRQ_EN builds only)
// Optional feature macro: GPIO_DEBOUNCE_IRQ_EN
// -----------------------------------------------------------------------------
module gpio_in_debounce
    import gpio_pkg::*;
#(
    parameter int             BIT             = 32'sd1,
    parameter int             DEBOUNCE_CYCLES = 32'sd16,
    parameter logic [BIT-1:0] RESET_VAL       = '0
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [BIT-1:0] pin,
    output logic [BIT-1:0] out,
    output logic [BIT-1:0] rise,
`ifdef GPIO_DEBOUNCE_IRQ_EN
    output logic [BIT-1:0] fall,
    input  logic [BIT-1:0] edge_clr,
    output logic           irq
`else
    output logic [BIT-1:0] fall
`endif
);

    for (genvar gi = 0; gi < BIT; gi++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[gi])
        ) u_bit (
            .clk    (clk),
            .resetn (resetn),
            .pin    (pin[gi]),
            .out    (out[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi])
        );
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [BIT-1:0] r_flag;
    logic [BIT-1:0] w_flag_next;
    logic           r_irq;

    // A pulse arriving together with a clear sets the flag, so no edge is lost.
    assign w_flag_next = (r_flag & ~edge_clr) | rise | fall;

    // Sticky flags; irq follows the next flag value so it rises one cycle after the pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_flag <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_flag <= w_flag_next;
            r_irq  <= |w_flag_next;
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// -----------------------------------------------------------------------------
// tb_gpio_in_debounce
// Directed scenarios followed by random pin activity, every cycle compared with
// a window-based reference: a bit flips when the last DEBOUNCE_CYCLES
// synchronised samples all differ from the current debounced level.
// -----------------------------------------------------------------------------
module tb_gpio_in_debounce;

    localparam int         BIT = 2;
    localparam int         DC  = 4;
    localparam logic [1:0] RV  = 2'b00;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] pin;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [1:0] edge_clr;
    logic       irq;
    logic [1:0] m_flag;
    logic       m_irq;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: pin samples taken at each edge, oldest first.
    logic [1:0] hist[$];
    logic [1:0] m_out;
    logic [1:0] m_rise;
    logic [1:0] m_fall;

    always #5 clk = ~clk;

    gpio_in_debounce #(
        .BIT             (BIT),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VAL       (RV)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .pin      (pin),
        .out      (out),
        .rise     (rise),
`ifdef GPIO_DEBOUNCE_IRQ_EN
        .fall     (fall),
        .edge_clr (edge_clr),
        .irq      (irq)
`else
        .fall     (fall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // After reset the synchroniser holds RESET_VAL, i.e. the pin "was" RV for ever.
    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DC + 2; i++) hist.push_back(RV);
        m_out  = RV;
        m_rise = 2'b00;
        m_fall = 2'b00;
`ifdef GPIO_DEBOUNCE_IRQ_EN
        m_flag = 2'b00;
        m_irq  = 1'b0;
`endif
    endtask

    // The filter at edge k sees pin samples from edges k-DC-1 .. k-2.
    task automatic model_edge();
        logic all_diff;
        hist.push_back(pin);
        if (hist.size() > DC + 2) void'(hist.pop_front());
        for (int b = 0; b < BIT; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) begin
                if (hist[j][b] == m_out[b]) all_diff = 1'b0;
            end
            m_rise[b] = all_diff & ~m_out[b];
            m_fall[b] = all_diff &  m_out[b];
            m_out[b]  = m_out[b] ^ all_diff;
        end
`ifdef GPIO_DEBOUNCE_IRQ_EN
        m_flag = (m_flag & ~edge_clr) | m_rise | m_fall;
        m_irq  = |m_flag;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out",  {30'd0, out},  {30'd0, m_out});
        chk("rise", {30'd0, rise}, {30'd0, m_rise});
        chk("fall", {30'd0, fall}, {30'd0, m_fall});
        chk("rise_fall_exclusive", {30'd0, rise & fall}, 32'd0);
`ifdef GPIO_DEBOUNCE_IRQ_EN
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    initial begin
        resetn = 1'b0;
        pin    = 2'b00;
`ifdef GPIO_DEBOUNCE_IRQ_EN
        edge_clr = 2'b00;
`endif
        model_reset();
        #12;
        chk("reset_out",  {30'd0, out},  32'd0);
        chk("reset_rise", {30'd0, rise}, 32'd0);
        chk("reset_fall", {30'd0, fall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Idle pins at reset level: nothing changes.
        for (int i = 0; i < 8; i++) tick();
        chk("idle_out", {30'd0, out}, 32'd0);

        // Single bit rise, accepted at edge DC+1.
        pin = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) chk("s2_out_before", {30'd0, out}, 32'd0);
            if (i == 5) chk("s2_rise_pulse", {30'd0, rise}, 32'd1);
            if (i == 6) chk("s2_rise_once", {30'd0, rise}, 32'd0);
        end
        pin = 2'b00;
        for (int i = 0; i < 8; i++) tick();

        // Glitch of DC-1 cycles is rejected.
        pin = 2'b01;
        for (int i = 0; i < DC - 1; i++) tick();
        pin = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("s3_no_pulse", {30'd0, rise | fall}, 32'd0);
        end
        chk("s3_out", {30'd0, out}, 32'd0);

        // Both bits together.
        pin = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 5) chk("s4_rise_both", {30'd0, rise}, 32'd3);
        end
        pin = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 5) chk("s4_fall_both", {30'd0, fall}, 32'd3);
        end

        // Reset mid-count discards progress; filtering restarts after release.
        pin = 2'b10;
        for (int i = 0; i < 4; i++) tick();
        resetn = 1'b0;
        #1;
        chk("s5_async_out",   {30'd0, out},         32'd0);
        chk("s5_async_pulse", {30'd0, rise | fall}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("s5_hold_out", {30'd0, out}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) chk("s5_out1_before", {31'd0, out[1]}, 32'd0);
            if (i == 5) chk("s5_out1_after",  {31'd0, out[1]}, 32'd1);
        end

`ifdef GPIO_DEBOUNCE_IRQ_EN
        // Sticky flag, clear, and clear coinciding with a new edge.
        pin = 2'b11;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 6) chk("s6_irq_set", {31'd0, irq}, 32'd1);
        end
        edge_clr = 2'b11;
        tick();
        chk("s6_irq_clr", {31'd0, irq}, 32'd0);
        edge_clr = 2'b00;
        pin = 2'b10;
        for (int i = 0; i < 6; i++) tick();
        edge_clr = 2'b01;
        tick();
        chk("s6_clr_vs_edge", {31'd0, irq}, 32'd1);
        edge_clr = 2'b00;
`endif

        // Random pin activity with hold times around the debounce length.
        for (int n = 0; n < 300; n++) begin
            int hold;
            pin  = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 2 * DC);
            for (int h = 0; h < hold; h++) begin
`ifdef GPIO_DEBOUNCE_IRQ_EN
                edge_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
`endif
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
